// File: rtl/wb_stage_pkg.sv
// Shared instruction encodings for the core: major opcodes and load/store widths.
// Also holds the small decode helper the writeback stage uses.
package wb_stage_pkg;

    localparam logic [6:0] OPC_LUI         = 7'b0110111;
    localparam logic [6:0] OPC_IMM_REG_ALU = 7'b0010011;
    localparam logic [6:0] OPC_REG_REG_ALU = 7'b0110011;
    localparam logic [6:0] OPC_LOAD        = 7'b0000011;
    localparam logic [6:0] OPC_STORE       = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic writes_rf(input logic [6:0] opcode);
        return (opcode == OPC_LUI) || (opcode == OPC_IMM_REG_ALU) ||
               (opcode == OPC_REG_REG_ALU) || (opcode == OPC_LOAD);
    endfunction

endpackage

// File: rtl/wb_stage_lsu_align.sv
// Byte-lane steering for data-memory accesses: store enables/lane shift,
// load extraction with sign/zero extension, and the alignment/width check.
module lsu_align
    import wb_stage_pkg::*;
#(
    parameter int unsigned BITSIZE = 32
) (
    input  logic [1:0]         addr_i,
    input  logic [2:0]         funct3_i,
    input  logic [6:0]         opcode_i,
    input  logic [BITSIZE-1:0] wdata_i,
    input  logic [BITSIZE-1:0] rdata_i,
    output logic [3:0]         be_o,
    output logic [BITSIZE-1:0] wdata_o,
    output logic [BITSIZE-1:0] rdata_o,
    output logic               misaligned_o
);

    logic [BITSIZE-1:0] byte_sh;
    logic [BITSIZE-1:0] half_sh;
    logic [7:0]         rbyte;
    logic [15:0]        rhalf;

    assign byte_sh = rdata_i >> {addr_i, 3'b000};
    assign half_sh = rdata_i >> {addr_i[1], 4'b0000};
    assign rbyte   = byte_sh[7:0];
    assign rhalf   = half_sh[15:0];

    always_comb begin
        be_o         = '0;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
        misaligned_o = 1'b0;
        if (opcode_i == OPC_LOAD) begin
            case (funct3_i)
                F3_LB:   rdata_o = {{(BITSIZE-8){rbyte[7]}}, rbyte};
                F3_LBU:  rdata_o = {{(BITSIZE-8){1'b0}}, rbyte};
                F3_LH: begin
                    misaligned_o = addr_i[0];
                    rdata_o      = {{(BITSIZE-16){rhalf[15]}}, rhalf};
                end
                F3_LHU: begin
                    misaligned_o = addr_i[0];
                    rdata_o      = {{(BITSIZE-16){1'b0}}, rhalf};
                end
                F3_LW:   misaligned_o = (addr_i != 2'b00);
                default: misaligned_o = 1'b1;
            endcase
        end else if (opcode_i == OPC_STORE) begin
            case (funct3_i)
                F3_SB: begin
                    be_o    = 4'b0001 << addr_i;
                    wdata_o = wdata_i << {addr_i, 3'b000};
                end
                F3_SH: begin
                    misaligned_o = addr_i[0];
                    be_o         = 4'b0011 << {addr_i[1], 1'b0};
                    wdata_o      = wdata_i << {addr_i[1], 4'b0000};
                end
                F3_SW: begin
                    misaligned_o = (addr_i != 2'b00);
                    be_o         = 4'hF;
                end
                default: misaligned_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts one executed instruction from EX, performs the
// optional data-memory access, writes the register file and counts retirements.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned BITSIZE = 32
) (
    input  logic               clk,
    input  logic               resetn_i,
    input  logic               EX_WB_give_i,
    output logic               WB_EX_get_o,
    input  logic [31:0]        EX_WB_instruction_i,
    input  logic [BITSIZE-1:0] EX_WB_d_i,
    input  logic [BITSIZE-1:0] EX_WB_rs2_i,
    output logic               WB_MEM_req_o,
    output logic               WB_MEM_we_o,
    output logic [BITSIZE-1:0] WB_MEM_addr_o,
    output logic [3:0]         WB_MEM_be_o,
    output logic [BITSIZE-1:0] WB_MEM_wdata_o,
    input  logic               MEM_WB_gnt_i,
    input  logic               MEM_WB_rvalid_i,
    input  logic [BITSIZE-1:0] MEM_WB_rdata_i,
    output logic               WB_RF_we_o,
    output logic [4:0]         WB_RF_rd_o,
    output logic [BITSIZE-1:0] WB_RF_d_o,
    output logic               WB_misaligned_o,
    output logic [31:0]        WB_instret_o
);

    typedef enum logic [1:0] {GET_INSTR, MEM_REQ, MEM_WAIT, WRITE_BACK} state_e;

    state_e             state_q;
    logic [6:0]         opc_q;
    logic [2:0]         f3_q;
    logic [4:0]         rd_q;
    logic [BITSIZE-1:0] d_q;
    logic [BITSIZE-1:0] rs2_q;
    logic [BITSIZE-1:0] rdata_q;
    logic               mis_q;
    logic [31:0]        instret_q;

    logic               transfer;
    logic               in_is_mem;
    logic [1:0]         lsu_addr;
    logic [2:0]         lsu_f3;
    logic [6:0]         lsu_opc;
    logic [3:0]         lsu_be;
    logic [BITSIZE-1:0] lsu_wdata;
    logic [BITSIZE-1:0] lsu_rdata;
    logic               lsu_mis;
    logic               unused_instr_bits;

    assign unused_instr_bits = ^EX_WB_instruction_i[31:15];

    assign WB_EX_get_o = (state_q == GET_INSTR) && resetn_i;
    assign transfer    = EX_WB_give_i && WB_EX_get_o;
    assign in_is_mem   = (EX_WB_instruction_i[6:0] == OPC_LOAD) ||
                         (EX_WB_instruction_i[6:0] == OPC_STORE);

    // One aligner serves both phases: the incoming instruction while idle (for the
    // alignment check at capture), the captured one during access and writeback.
    always_comb begin
        if (state_q == GET_INSTR) begin
            lsu_addr = EX_WB_d_i[1:0];
            lsu_f3   = EX_WB_instruction_i[14:12];
            lsu_opc  = EX_WB_instruction_i[6:0];
        end else begin
            lsu_addr = d_q[1:0];
            lsu_f3   = f3_q;
            lsu_opc  = opc_q;
        end
    end

    lsu_align #(.BITSIZE(BITSIZE)) u_lsu_align (
        .addr_i       (lsu_addr),
        .funct3_i     (lsu_f3),
        .opcode_i     (lsu_opc),
        .wdata_i      (rs2_q),
        .rdata_i      (rdata_q),
        .be_o         (lsu_be),
        .wdata_o      (lsu_wdata),
        .rdata_o      (lsu_rdata),
        .misaligned_o (lsu_mis)
    );

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= GET_INSTR;
            opc_q     <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            d_q       <= '0;
            rs2_q     <= '0;
            rdata_q   <= '0;
            mis_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            case (state_q)
                GET_INSTR: begin
                    if (transfer) begin
                        opc_q <= EX_WB_instruction_i[6:0];
                        f3_q  <= EX_WB_instruction_i[14:12];
                        rd_q  <= EX_WB_instruction_i[11:7];
                        d_q   <= EX_WB_d_i;
                        rs2_q <= EX_WB_rs2_i;
                        mis_q <= lsu_mis;
                        state_q <= (in_is_mem && !lsu_mis) ? MEM_REQ : WRITE_BACK;
                    end
                end
                MEM_REQ: begin
                    if (MEM_WB_gnt_i) state_q <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (MEM_WB_rvalid_i) begin
                        rdata_q <= MEM_WB_rdata_i;
                        state_q <= WRITE_BACK;
                    end
                end
                WRITE_BACK: begin
                    instret_q <= instret_q + 32'd1;
                    state_q   <= GET_INSTR;
                end
                default: state_q <= GET_INSTR;
            endcase
        end
    end

    assign WB_MEM_req_o   = (state_q == MEM_REQ);
    assign WB_MEM_we_o    = WB_MEM_req_o && (opc_q == OPC_STORE);
    assign WB_MEM_addr_o  = WB_MEM_req_o ? {d_q[BITSIZE-1:2], 2'b00} : '0;
    assign WB_MEM_be_o    = WB_MEM_we_o ? lsu_be : '0;
    assign WB_MEM_wdata_o = WB_MEM_we_o ? lsu_wdata : '0;

    assign WB_RF_we_o      = (state_q == WRITE_BACK) && writes_rf(opc_q) &&
                             (rd_q != 5'd0) && !mis_q;
    assign WB_RF_rd_o      = rd_q;
    assign WB_RF_d_o       = (opc_q == OPC_LOAD) ? lsu_rdata : d_q;
    assign WB_misaligned_o = (state_q == WRITE_BACK) && mis_q;
    assign WB_instret_o    = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU writeback, loads/stores with lane steering,
// misaligned accesses and reset in the middle of a memory access.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        resetn_i;
    logic        EX_WB_give_i;
    logic        WB_EX_get_o;
    logic [31:0] EX_WB_instruction_i;
    logic [31:0] EX_WB_d_i;
    logic [31:0] EX_WB_rs2_i;
    logic        WB_MEM_req_o;
    logic        WB_MEM_we_o;
    logic [31:0] WB_MEM_addr_o;
    logic [3:0]  WB_MEM_be_o;
    logic [31:0] WB_MEM_wdata_o;
    logic        MEM_WB_gnt_i;
    logic        MEM_WB_rvalid_i;
    logic [31:0] MEM_WB_rdata_i;
    logic        WB_RF_we_o;
    logic [4:0]  WB_RF_rd_o;
    logic [31:0] WB_RF_d_o;
    logic        WB_misaligned_o;
    logic [31:0] WB_instret_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    wb_stage #(.BITSIZE(32)) dut (
        .clk                 (clk),
        .resetn_i            (resetn_i),
        .EX_WB_give_i        (EX_WB_give_i),
        .WB_EX_get_o         (WB_EX_get_o),
        .EX_WB_instruction_i (EX_WB_instruction_i),
        .EX_WB_d_i           (EX_WB_d_i),
        .EX_WB_rs2_i         (EX_WB_rs2_i),
        .WB_MEM_req_o        (WB_MEM_req_o),
        .WB_MEM_we_o         (WB_MEM_we_o),
        .WB_MEM_addr_o       (WB_MEM_addr_o),
        .WB_MEM_be_o         (WB_MEM_be_o),
        .WB_MEM_wdata_o      (WB_MEM_wdata_o),
        .MEM_WB_gnt_i        (MEM_WB_gnt_i),
        .MEM_WB_rvalid_i     (MEM_WB_rvalid_i),
        .MEM_WB_rdata_i      (MEM_WB_rdata_i),
        .WB_RF_we_o          (WB_RF_we_o),
        .WB_RF_rd_o          (WB_RF_rd_o),
        .WB_RF_d_o           (WB_RF_d_o),
        .WB_misaligned_o     (WB_misaligned_o),
        .WB_instret_o        (WB_instret_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hands one instruction to the DUT; returns one cycle after the transfer edge.
    task automatic xfer(input logic [31:0] instr, input logic [31:0] d, input logic [31:0] rs2);
        EX_WB_give_i        = 1'b1;
        EX_WB_instruction_i = instr;
        EX_WB_d_i           = d;
        EX_WB_rs2_i         = rs2;
        step();
        EX_WB_give_i        = 1'b0;
    endtask

    // Zero-wait access: gnt in the first request cycle, rvalid the next; returns in WRITE_BACK.
    task automatic mem_txn(input logic [31:0] instr, input logic [31:0] d, input logic [31:0] rdata);
        xfer(instr, d, 32'h0);
        MEM_WB_gnt_i = 1'b1;
        step();
        MEM_WB_gnt_i    = 1'b0;
        MEM_WB_rvalid_i = 1'b1;
        MEM_WB_rdata_i  = rdata;
        step();
        MEM_WB_rvalid_i = 1'b0;
    endtask

    initial begin
        resetn_i = 1'b0;
        EX_WB_give_i = 1'b0;
        EX_WB_instruction_i = '0;
        EX_WB_d_i = '0;
        EX_WB_rs2_i = '0;
        MEM_WB_gnt_i = 1'b0;
        MEM_WB_rvalid_i = 1'b0;
        MEM_WB_rdata_i = '0;
        #2;
        check("rst_get", {31'b0, WB_EX_get_o}, 32'h0);
        check("rst_req", {31'b0, WB_MEM_req_o}, 32'h0);
        check("rst_rfwe", {31'b0, WB_RF_we_o}, 32'h0);
        check("rst_instret", WB_instret_o, 32'h0);
        step();
        step();
        resetn_i = 1'b1;
        #1;
        check("idle_get", {31'b0, WB_EX_get_o}, 32'h1);

        // ADDI x5, d=7
        xfer(32'h0000_0293, 32'h7, 32'h0);
        check("addi_we", {31'b0, WB_RF_we_o}, 32'h1);
        check("addi_rd", {27'b0, WB_RF_rd_o}, 32'd5);
        check("addi_d", WB_RF_d_o, 32'h7);
        check("addi_get_busy", {31'b0, WB_EX_get_o}, 32'h0);
        check("addi_req", {31'b0, WB_MEM_req_o}, 32'h0);
        step();
        check("addi_get_back", {31'b0, WB_EX_get_o}, 32'h1);
        check("addi_instret", WB_instret_o, 32'd1);

        // REG_REG_ALU to x0
        xfer(32'h0000_0033, 32'h1234, 32'h0);
        check("x0_we", {31'b0, WB_RF_we_o}, 32'h0);
        check("x0_mis", {31'b0, WB_misaligned_o}, 32'h0);
        step();
        check("x0_instret", WB_instret_o, 32'd2);

        // LB x6 @0x103, gnt after 3 wait cycles, stray rvalid during MEM_REQ
        xfer(32'h0000_0303, 32'h103, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("lb_req", {31'b0, WB_MEM_req_o}, 32'h1);
            check("lb_addr", WB_MEM_addr_o, 32'h100);
            check("lb_we", {31'b0, WB_MEM_we_o}, 32'h0);
            MEM_WB_rvalid_i = (i == 1);
            MEM_WB_gnt_i    = (i == 3);
            step();
        end
        MEM_WB_gnt_i = 1'b0;
        check("lb_wait_req", {31'b0, WB_MEM_req_o}, 32'h0);
        MEM_WB_rvalid_i = 1'b1;
        MEM_WB_rdata_i  = 32'h80AA_BBCC;
        step();
        MEM_WB_rvalid_i = 1'b0;
        check("lb_we_rf", {31'b0, WB_RF_we_o}, 32'h1);
        check("lb_rd", {27'b0, WB_RF_rd_o}, 32'd6);
        check("lb_d", WB_RF_d_o, 32'hFFFF_FF80);
        step();
        check("lb_instret", WB_instret_o, 32'd3);

        // SH @0x102, rs2=0x1234
        xfer(32'h0000_1023, 32'h102, 32'h0000_1234);
        check("sh_req", {31'b0, WB_MEM_req_o}, 32'h1);
        check("sh_we", {31'b0, WB_MEM_we_o}, 32'h1);
        check("sh_addr", WB_MEM_addr_o, 32'h100);
        check("sh_be", {28'b0, WB_MEM_be_o}, 32'hC);
        check("sh_wdata", WB_MEM_wdata_o, 32'h1234_0000);
        MEM_WB_gnt_i = 1'b1;
        step();
        MEM_WB_gnt_i = 1'b0;
        MEM_WB_rvalid_i = 1'b1;
        step();
        MEM_WB_rvalid_i = 1'b0;
        check("sh_rfwe", {31'b0, WB_RF_we_o}, 32'h0);
        check("sh_mis", {31'b0, WB_misaligned_o}, 32'h0);
        step();
        check("sh_instret", WB_instret_o, 32'd4);

        // LW x7 @0x101: misaligned
        xfer(32'h0000_2383, 32'h101, 32'h0);
        check("lwmis_req", {31'b0, WB_MEM_req_o}, 32'h0);
        check("lwmis_pulse", {31'b0, WB_misaligned_o}, 32'h1);
        check("lwmis_rfwe", {31'b0, WB_RF_we_o}, 32'h0);
        step();
        check("lwmis_pulse_end", {31'b0, WB_misaligned_o}, 32'h0);
        check("lwmis_instret", WB_instret_o, 32'd5);

        // LH / LHU x10 @0x102, LBU x10 @0x101
        mem_txn(32'h0000_1503, 32'h102, 32'h8001_0000);
        check("lh_d", WB_RF_d_o, 32'hFFFF_8001);
        step();
        mem_txn(32'h0000_5503, 32'h102, 32'h8001_0000);
        check("lhu_d", WB_RF_d_o, 32'h0000_8001);
        step();
        mem_txn(32'h0000_4503, 32'h101, 32'h1234_F156);
        check("lbu_d", WB_RF_d_o, 32'h0000_00F1);
        step();
        check("lbu_instret", WB_instret_o, 32'd8);

        // SB @0x003, rs2=0xAB
        xfer(32'h0000_0023, 32'h003, 32'h0000_00AB);
        check("sb_be", {28'b0, WB_MEM_be_o}, 32'h8);
        check("sb_wdata", WB_MEM_wdata_o, 32'hAB00_0000);
        check("sb_addr", WB_MEM_addr_o, 32'h0);
        MEM_WB_gnt_i = 1'b1;
        step();
        MEM_WB_gnt_i = 1'b0;
        MEM_WB_rvalid_i = 1'b1;
        step();
        MEM_WB_rvalid_i = 1'b0;
        step();

        // Illegal load width funct3=011
        xfer(32'h0000_3503, 32'h100, 32'h0);
        check("f3bad_req", {31'b0, WB_MEM_req_o}, 32'h0);
        check("f3bad_mis", {31'b0, WB_misaligned_o}, 32'h1);
        check("f3bad_rfwe", {31'b0, WB_RF_we_o}, 32'h0);
        step();

        // LUI x11
        xfer(32'h0000_05B7, 32'hABCD_E000, 32'h0);
        check("lui_we", {31'b0, WB_RF_we_o}, 32'h1);
        check("lui_d", WB_RF_d_o, 32'hABCD_E000);
        step();
        check("lui_instret", WB_instret_o, 32'd11);

        // Reset while in MEM_WAIT, then stray rvalid after release
        xfer(32'h0000_2403, 32'h200, 32'h0);
        MEM_WB_gnt_i = 1'b1;
        step();
        MEM_WB_gnt_i = 1'b0;
        resetn_i = 1'b0;
        #1;
        check("mrst_get", {31'b0, WB_EX_get_o}, 32'h0);
        check("mrst_req", {31'b0, WB_MEM_req_o}, 32'h0);
        check("mrst_instret", WB_instret_o, 32'h0);
        check("mrst_rfwe", {31'b0, WB_RF_we_o}, 32'h0);
        step();
        resetn_i = 1'b1;
        MEM_WB_rvalid_i = 1'b1;
        MEM_WB_rdata_i  = 32'hDEAD_BEEF;
        #1;
        check("mrst_get_back", {31'b0, WB_EX_get_o}, 32'h1);
        step();
        MEM_WB_rvalid_i = 1'b0;
        check("mrst_ign_rfwe", {31'b0, WB_RF_we_o}, 32'h0);
        check("mrst_ign_get", {31'b0, WB_EX_get_o}, 32'h1);
        check("mrst_ign_instret", WB_instret_o, 32'h0);
        xfer(32'h0000_0493, 32'h55, 32'h0);
        check("post_we", {31'b0, WB_RF_we_o}, 32'h1);
        check("post_rd", {27'b0, WB_RF_rd_o}, 32'd9);
        check("post_d", WB_RF_d_o, 32'h55);
        step();
        check("post_instret", WB_instret_o, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
